// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: function-select codes, FSM states and status-flag layout.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHR1 = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_ZERO = 3'b110;
  localparam logic [2:0] OP_ONES = 3'b111;

  localparam logic [2:0] XOP_SHR = 3'b000;
  localparam logic [2:0] XOP_SHL = 3'b001;
  localparam logic [2:0] XOP_ASR = 3'b010;
  localparam logic [2:0] XOP_MUL = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;

  localparam int STAT_V = 3;
  localparam int STAT_C = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

  function automatic logic [3:0] pack_stat(input logic v, input logic c, input logic n, input logic z);
    logic [3:0] s;
    s         = '0;
    s[STAT_V] = v;
    s[STAT_C] = c;
    s[STAT_N] = n;
    s[STAT_Z] = z;
    return s;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational legacy ALU datapath (optional operand inversion) with its V/C/N/Z flags.
// Zero latency; no flow control of its own.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_inv_a,
  input  logic             i_inv_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_f,
  output logic [3:0]       o_stat
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_v;

  assign w_a   = i_inv_a ? ~i_a : i_a;
  assign w_b   = i_inv_b ? ~i_b : i_b;
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};

  always_comb begin
    o_f = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (i_op)
      OP_AND: o_f = w_a & w_b;
      OP_OR:  o_f = w_a | w_b;
      OP_ADD: begin
        o_f = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_v = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_XOR: o_f = w_a ^ w_b;
      // single-bit shifts report the bit that falls off as carry
      OP_SHR1: begin
        o_f = {1'b0, w_a[WIDTH-1:1]};
        w_c = w_a[0];
      end
      OP_SHL1: begin
        o_f = {w_a[WIDTH-2:0], 1'b0};
        w_c = w_a[WIDTH-1];
      end
      OP_ZERO: o_f = '0;
      default: o_f = '1;
    endcase
  end

  assign o_stat = pack_stat(w_v, w_c, o_f[WIDTH-1], ~|o_f);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle legacy ops, bit-serial variable shifts, shift-add multiply.
// Result registered on accept (+s or +WIDTH cycles for shift/MUL); in_ready low while busy or result stalled.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       FS,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       stat,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_f;
  logic [3:0]       r_stat;
  logic             r_err;
  logic             r_vld;

  logic [SHW-1:0]   w_s;
  logic             w_ext;
  logic             w_rsvd;
  logic             w_mul;
  logic             w_shift_multi;
  logic             w_accept;
  logic [WIDTH-1:0] w_core_f;
  logic [3:0]       w_core_stat;
  logic [WIDTH-1:0] w_sc_f;
  logic [3:0]       w_sc_stat;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_c;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_s           = B[SHW-1:0];
  assign w_ext         = FS[5];
  assign w_rsvd        = w_ext && FS[4];
  assign w_mul         = w_ext && (FS[4:2] == XOP_MUL);
  assign w_shift_multi = w_ext && !FS[4] && !w_mul && (w_s != '0);
  assign in_ready      = (r_state == ST_IDLE) && (!r_vld || out_ready);
  assign w_accept      = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a     (A),
    .i_b     (B),
    .i_op    (FS[4:2]),
    .i_inv_a (FS[1]),
    .i_inv_b (FS[0]),
    .i_cin   (Cin),
    .o_f     (w_core_f),
    .o_stat  (w_core_stat)
  );

  // zero-length extended shifts pass A through untouched; reserved codes force zero
  assign w_sc_f    = !w_ext ? w_core_f : (w_rsvd ? '0 : A);
  assign w_sc_stat = !w_ext ? w_core_stat
                            : pack_stat(1'b0, 1'b0, w_sc_f[WIDTH-1], ~|w_sc_f);

  always_comb begin
    w_sh_next = {1'b0, r_lo[WIDTH-1:1]};
    w_sh_c    = r_lo[0];
    case (r_op)
      XOP_SHL: begin
        w_sh_next = {r_lo[WIDTH-2:0], 1'b0};
        w_sh_c    = r_lo[WIDTH-1];
      end
      XOP_ASR: w_sh_next = {r_lo[WIDTH-1], r_lo[WIDTH-1:1]};
      default: ;
    endcase
  end

  // {r_hi, r_lo} walks right one multiplier bit per cycle; r_lo starts as B
  assign w_mul_sum = {1'b0, r_hi} + {1'b0, r_opa & {WIDTH{r_lo[0]}}};
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_f     <= '0;
      r_stat  <= '0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      if (out_ready) r_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_mul) begin
              r_state <= ST_MUL;
              r_cnt   <= MUL_ITERS;
              r_opa   <= A;
              r_hi    <= '0;
              r_lo    <= B;
            end else if (w_shift_multi) begin
              r_state <= ST_SHIFT;
              r_cnt   <= {1'b0, w_s};
              r_op    <= FS[4:2];
              r_lo    <= A;
            end else begin
              r_f    <= w_sc_f;
              r_stat <= w_sc_stat;
              r_err  <= w_rsvd;
              r_vld  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_lo  <= w_sh_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_f     <= w_sh_next;
            r_stat  <= pack_stat(1'b0, w_sh_c, w_sh_next[WIDTH-1], ~|w_sh_next);
            r_err   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_f     <= w_mul_lo;
            r_stat  <= pack_stat(1'b0, |w_mul_hi, w_mul_lo[WIDTH-1], ~|w_mul_lo);
            r_err   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_vld;
  assign F         = r_f;
  assign stat      = r_stat;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: fixed vector table, hand-built handshake/reset sequences,
// and random requests compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W  = 64;
  localparam int NV = 13;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [5:0]   FS;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] F;
  logic [3:0]   stat;
  logic         err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .FS        (FS),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .stat      (stat),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   fs;
    logic         cin;
    logic [W-1:0] f;
    logic [3:0]   st;
    logic         er;
    int           lat;
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: results straight from the operation definitions; lat counts edges from accept to result.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [5:0] fs, input logic ci,
                                    output logic [W-1:0] f, output logic [3:0] st,
                                    output logic er, output int lat);
    logic [W-1:0]        x, y;
    logic signed [W-1:0] sa;
    logic [W:0]          s65;
    logic [2*W-1:0]      p;
    logic                c, v;
    int                  s;
    c = 1'b0; v = 1'b0; er = 1'b0; lat = 1; f = '0;
    if (!fs[5]) begin
      x = fs[1] ? ~a : a;
      y = fs[0] ? ~b : b;
      case (fs[4:2])
        3'd0: f = x & y;
        3'd1: f = x | y;
        3'd2: begin
          s65 = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
          f = s65[W-1:0];
          c = s65[W];
          v = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
        end
        3'd3: f = x ^ y;
        3'd4: begin f = x >> 1; c = x[0]; end
        3'd5: begin f = x << 1; c = x[W-1]; end
        3'd6: f = '0;
        default: f = '1;
      endcase
    end else begin
      s = int'(b[5:0]);
      case (fs[4:2])
        3'd0: begin f = a >> s; c = (s != 0) ? a[s-1] : 1'b0; lat = s + 1; end
        3'd1: begin f = a << s; c = (s != 0) ? a[W-s] : 1'b0; lat = s + 1; end
        3'd2: begin sa = a; f = sa >>> s; c = (s != 0) ? a[s-1] : 1'b0; lat = s + 1; end
        3'd3: begin
          p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          f = p[W-1:0];
          c = |p[2*W-1:W];
          lat = W + 1;
        end
        default: begin f = '0; er = 1'b1; end
      endcase
    end
    st = {v, c, f[W-1], (f == '0)};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] fs,
                        input logic ci, output logic [W-1:0] f, output logic [3:0] st,
                        output logic er, output int lat);
    int guard;
    bit leak;
    guard = 0;
    leak  = 1'b0;
    @(negedge clock);
    A = a; B = b; FS = fs; Cin = ci; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=0 want 1");
    end
    @(posedge clock);
    #1;
    // scramble inputs to show the request was captured at accept
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    FS = 6'($urandom);
    Cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) leak = 1'b1;
      @(posedge clock);
      #1;
      lat++;
    end
    f = F; st = stat; er = err;
    if (lat > 1) chk("in_ready_busy", W'(leak), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] f, rf;
    logic [3:0]   st, rst;
    logic         er, rer;
    int           lat, rlat;
    logic [5:0]   seq_fs [4];
    logic [W-1:0] seq_f  [4];
    bit           seen;

    vt[0]  = '{64'd13, 64'd6, 6'h09, 1'b1, 64'd7, 4'b0100, 1'b0, 1};
    vt[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'h08, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, 1'b0, 1};
    vt[2]  = '{64'd1, 64'd4, 6'h24, 1'b0, 64'd16, 4'b0000, 1'b0, 5};
    vt[3]  = '{64'h8000_0000_0000_0000, 64'd63, 6'h28, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1'b0, 64};
    vt[4]  = '{64'd13, 64'd6, 6'h2C, 1'b0, 64'd78, 4'b0000, 1'b0, 65};
    vt[5]  = '{64'h1_0000_0000, 64'h1_0000_0000, 6'h2C, 1'b0, 64'd0, 4'b0101, 1'b0, 65};
    vt[6]  = '{64'd5, 64'd9, 6'h30, 1'b0, 64'd0, 4'b0001, 1'b1, 1};
    vt[7]  = '{64'h80, 64'd64, 6'h20, 1'b0, 64'h80, 4'b0000, 1'b0, 1};
    vt[8]  = '{64'd3, 64'd3, 6'h1C, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1'b0, 1};
    vt[9]  = '{64'h8000_0000_0000_0001, 64'd0, 6'h14, 1'b0, 64'd2, 4'b0100, 1'b0, 1};
    vt[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'h08, 1'b0, 64'd0, 4'b0101, 1'b0, 1};
    vt[11] = '{64'hF0, 64'h0F, 6'h03, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 4'b0010, 1'b0, 1};
    vt[12] = '{64'h8000_0000_0000_0003, 64'd1, 6'h20, 1'b0, 64'h4000_0000_0000_0001, 4'b0100, 1'b0, 2};

    seq_fs[0] = 6'h00; seq_fs[1] = 6'h04; seq_fs[2] = 6'h08; seq_fs[3] = 6'h0C;
    seq_f[0]  = 64'd4; seq_f[1]  = 64'd15; seq_f[2] = 64'd19; seq_f[3] = 64'd11;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; FS = '0; Cin = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_F", F, W'(0));
    chk("rst_stat", W'(stat), W'(0));
    chk("rst_err", W'(err), W'(0));
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].fs, vt[i].cin, f, st, er, lat);
      chk($sformatf("vec%0d_F", i), f, vt[i].f);
      chk($sformatf("vec%0d_stat", i), W'(st), W'(vt[i].st));
      chk($sformatf("vec%0d_err", i), W'(er), W'(vt[i].er));
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(vt[i].lat));
    end

    // back-to-back legacy ops, one result per cycle
    @(negedge clock);
    A = 64'd13; B = 64'd6; Cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      FS = seq_fs[i];
      @(posedge clock);
      #1;
      chk($sformatf("b2b%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("b2b%0d_F", i), F, seq_f[i]);
      if (i == 2) chk("b2b_add_stat", W'(stat), W'(0));
    end
    in_valid = 1'b0;

    // stalled consumer, then drain and accept on the same edge
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    run_op(64'd5, 64'd6, 6'h08, 1'b0, f, st, er, lat);
    chk("bp_first_F", f, 64'd11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bp%0d_F", i), F, 64'd11);
      chk($sformatf("bp%0d_stat", i), W'(stat), W'(0));
      chk($sformatf("bp%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("bp%0d_in_ready", i), W'(in_ready), W'(0));
    end
    @(negedge clock);
    A = 64'd9; B = 64'd3; FS = 6'h0C; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("drain_in_ready", W'(in_ready), W'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("drain_valid", W'(out_valid), W'(1));
    chk("drain_F", F, 64'd10);
    @(posedge clock);
    #1;
    chk("drain_then_idle", W'(out_valid), W'(0));

    // reset in the middle of a multiply
    run_op(64'd0, 64'd0, 6'h1C, 1'b0, f, st, er, lat);
    @(negedge clock);
    A = 64'd13; B = 64'd6; FS = 6'h2C; Cin = 1'b0; in_valid = 1'b1;
    chk("mul_accept_rdy", W'(in_ready), W'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midmul_rst_valid", W'(out_valid), W'(0));
    chk("midmul_rst_F", F, W'(0));
    chk("midmul_rst_in_ready", W'(in_ready), W'(1));
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midmul_discarded", W'(seen), W'(0));
    run_op(64'd100, 64'd23, 6'h08, 1'b0, f, st, er, lat);
    chk("post_rst_add_F", f, 64'd123);
    chk("post_rst_add_lat", W'(lat), W'(1));
    run_op(64'd77, 64'd1, 6'h30, 1'b0, f, st, er, lat);
    chk("post_rst_rsvd_err", W'(er), W'(1));
    chk("post_rst_rsvd_F", f, W'(0));
    chk("post_rst_rsvd_stat", W'(st), W'(4'b0001));

    // random requests against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic [5:0]   rfs;
      logic         rci;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rfs = 6'($urandom);
      rci = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      ref_model(ra, rb, rfs, rci, rf, rst, rer, rlat);
      run_op(ra, rb, rfs, rci, f, st, er, lat);
      chk($sformatf("rnd%0d_fs%h_F", i, rfs), f, rf);
      chk($sformatf("rnd%0d_fs%h_stat", i, rfs), W'(st), W'(rst));
      chk($sformatf("rnd%0d_fs%h_err", i, rfs), W'(er), W'(rer));
      chk($sformatf("rnd%0d_fs%h_lat", i, rfs), W'(lat), W'(rlat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
